// File: rtl/add64_seq.sv
// add64_seq: multi-cycle 64-bit adder.
// The sum (A + B + Cin) mod 2^64 is computed in four 16-bit slices, one per
// clock, with a registered carry between slices. Operands are captured on an
// accepted Start and the result is published on the completing edge.
//
// Ports:
//   Clk    in   1   system clock, rising edge
//   Reset  in   1   asynchronous active-low reset
//   Start  in   1   request, sampled only in IDLE
//   A, B   in  64   operands, captured on accepted Start
//   Cin    in   1   carry into bit 0, captured on accepted Start
//   Busy   out  1   high whenever not IDLE
//   Done   out  1   single-cycle completion pulse
//   out    out 64   sum register
//   Cout   out  1   carry out of bit 63
//   Ovf    out  1   two's-complement overflow
module add64_seq (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
  output logic        Busy,
  output logic        Done,
  output logic [63:0] out,
  output logic        Cout,
  output logic        Ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [47:0] psum_q;     // slices 0..2; slice 3 goes straight into out
  logic        carry_q;
  logic [1:0]  k_q;

  logic [15:0] a_sl;
  logic [15:0] b_sl;
  logic [16:0] slice_sum;

  always_comb begin
    a_sl      = a_q[{k_q, 4'b0000} +: 16];
    b_sl      = b_q[{k_q, 4'b0000} +: 16];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {16'b0, carry_q};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      out     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            k_q     <= '0;
            Busy    <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          carry_q <= slice_sum[16];
          k_q     <= k_q + 2'd1;
          case (k_q)
            2'd0: psum_q[15:0]  <= slice_sum[15:0];
            2'd1: psum_q[31:16] <= slice_sum[15:0];
            2'd2: psum_q[47:32] <= slice_sum[15:0];
            default: begin
              // Final slice: publish the whole result in one edge so out
              // never shows a partially updated sum.
              out     <= {slice_sum[15:0], psum_q};
              Cout    <= slice_sum[16];
              Ovf     <= (a_q[63] == b_q[63]) && (slice_sum[15] != a_q[63]);
              Done    <= 1'b1;
              state_q <= DONE;
            end
          endcase
        end

        DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/add64_seq.md
# add64_seq

Multi-cycle 64-bit adder that performs the inverse of the datapath's 64-bit subtract: given a difference and the subtrahend, it recovers the minuend. It is also the general 64-bit add unit. It takes operands through a start/done handshake and computes the sum in four 16-bit slices, one slice per clock, propagating a registered carry between slices. It sits beside the combinational subtractor in the execute stage and is used for wide add operations that must not lengthen the critical path.

## Interface
- No parameters. Width is fixed at 64 bits; slice width is fixed at 16 bits, giving 4 slices.
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
- Start  input  1  request; sampled only in IDLE.
- A  input  64  first operand; captured on an accepted Start.
- B  input  64  second operand; captured on an accepted Start.
- Cin  input  1  carry-in to bit 0; captured on an accepted Start.
- Busy  output  1  high whenever the state is not IDLE.
- Done  output  1  single-cycle completion pulse.
- out  output  64  sum register, equal to (A + B + Cin) mod 2^64.
- Cout  output  1  carry out of bit 63.
- Ovf  output  1  signed overflow flag.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE. Encoding is free.
- Reset values: Busy=0, Done=0, out=0, Cout=0, Ovf=0. Internal slice index and carry are also 0.
- IDLE:
  - On a rising edge with Start=1, latch A, B and Cin into internal operand registers.
  - Clear the slice index k to 0, seed the carry register with Cin, and go to RUN.
  - With Start=0, remain in IDLE.
- RUN: each edge computes {c, s} = A_l[16k+15:16k] + B_l[16k+15:16k] + carry.
  - Write s into internal partial-sum slice k, set carry to c, and increment k.
  - On the edge where k=3 is processed:
    - Load out from the full partial sum and load Cout from the final carry.
    - Set Ovf = (A_l[63]==B_l[63]) && (sum[63]!=A_l[63]).
    - Set Done=1 and go to DONE.
- DONE: Done=1 for exactly this one cycle. The next edge clears Done and returns to IDLE.
- Start is ignored in RUN and DONE. There is no queuing. Operands are not re-sampled during RUN, so input changes after acceptance have no effect.
- out, Cout and Ovf change only on the completing edge. They hold their value until the next completion or a reset, and never expose partial slices.
- Arithmetic is unsigned modulo 2^64. Cout is the unsigned carry; Ovf is two's-complement overflow.
- Reset asserted mid-operation aborts immediately: state returns to IDLE, all outputs go to their reset values, and no Done is issued.

## Timing
- Edge t0 samples Start=1 in IDLE.
- Slices 0, 1, 2 and 3 are computed at edges t1, t2, t3 and t4.
- Results become valid and Done rises after t4. Done falls after t5.
- Latency from the Start sample to Done high is 4 edges.
- Busy is high from after t0 until after t5.
- Holding Start high starts a new operation at t6, giving a minimum issue interval of 6 cycles.
- Reset is asynchronous on assertion. Deassertion must meet recovery timing relative to Clk.

## Test plan
- Reset behaviour: assert Reset=0 mid-cycle with random inputs -> Busy, Done, out, Cout and Ovf are all 0 immediately, with no clock edge needed.
- Wrap across all slices: A=0xFFFF_FFFF_FFFF_FFFF, B=1, Cin=0 -> after 4 edges out=0, Cout=1, Ovf=0, and Done is high for exactly 1 cycle.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, Cin=0 -> out=0x8000_0000_0000_0000, Cout=0, Ovf=1.
- Inverse of subtract: A=0xFFFF_FFFF_FFFF_FFF0 (0x10-0x20), B=0x20, Cin=0 -> out=0x10, Cout=1, Ovf=0.
- Inter-slice carry and Cin: A=0x0000_0000_0000_FFFF, B=0, Cin=1 -> out=0x0000_0000_0001_0000.
  - Changing A and B during RUN does not alter the result.
- Handshake and abort:
  - Pulse Start in RUN and in DONE -> ignored.
  - Hold Start high -> a second Done arrives exactly 6 cycles after the first.
  - Assert Reset at t2 -> no Done, and out=0.
